// File: rtl/ct_l2c_sram_4096x84_ctrl.sv
// Init sweep plus write/read arbiter for one single-port L2C array.
// Latency: SRAM pins register the grant one cycle later; read data returns two cycles after rd grant.
// Backpressure: wr_rdy/rd_rdy go high only for the cycle's winner; both stay low until the sweep completes.
module ct_l2c_sram_4096x84_ctrl #(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 84,
    parameter int                    STARVE_LIMIT = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = 84'h0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  wr_vld,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bwe,
    output logic                  wr_rdy,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rdy,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [0:0]          state;
    logic [ADDR_WIDTH:0] init_cnt;
    logic [1:0]          starve_cnt;
    logic                rd_p1;
    logic                rd_p2;
    logic                run;
    logic                sweep_act;
    logic                starve_hit;
    logic                wr_gnt;
    logic                rd_gnt;

    assign run        = (state == ST_RUN);
    // The extra counter bit marks "all entries written"; that cycle is the gap before RUN.
    assign sweep_act  = !run && !init_cnt[ADDR_WIDTH];
    assign starve_hit = rd_vld && (starve_cnt == STARVE_MAX);
    assign wr_gnt     = run && wr_vld && !starve_hit;
    assign rd_gnt     = run && rd_vld && !wr_gnt;

    assign wr_rdy      = wr_gnt;
    assign rd_rdy      = rd_gnt;
    assign init_done   = run;
    assign rd_data_vld = rd_p2;
    assign rd_data     = sram_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (!run) begin
            if (sweep_act) begin
                init_cnt <= init_cnt + CNT_ONE;
            end else begin
                state <= ST_RUN;
            end
        end
    end

    // Counts writes that overtook a waiting read; any read grant or idle read side clears it.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            starve_cnt <= 2'd0;
        end else if (!rd_vld || rd_gnt) begin
            starve_cnt <= 2'd0;
        end else if (wr_gnt && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
        end else if (sweep_act) begin
            sram_cen  <= 1'b0;
            sram_gwen <= 1'b0;
            sram_wen  <= '0;
            sram_a    <= init_cnt[ADDR_WIDTH-1:0];
            sram_d    <= INIT_VALUE;
        end else if (wr_gnt) begin
            sram_cen  <= 1'b0;
            sram_gwen <= 1'b0;
            sram_wen  <= ~wr_bwe;
            sram_a    <= wr_addr;
            sram_d    <= wr_data;
        end else if (rd_gnt) begin
            sram_cen  <= 1'b0;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= rd_addr;
        end else begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_p1 <= 1'b0;
            rd_p2 <= 1'b0;
        end else begin
            rd_p1 <= rd_gnt;
            rd_p2 <= rd_p1;
        end
    end

endmodule

// File: tb/tb_ct_l2c_sram_4096x84_ctrl.sv
// Bench for the L2C array controller: behavioural SRAM, reference memory and arbitration model.
module tb_ct_l2c_sram_4096x84_ctrl;

    localparam int AW = 12;
    localparam int DW = 84;
    localparam int STARVE_LIMIT = 3;
    localparam logic [DW-1:0] INIT = 84'h0;

    logic          forever_cpuclk;
    logic          cpurst_b;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_bwe;
    logic          wr_rdy;
    logic          rd_vld;
    logic [AW-1:0] rd_addr;
    logic          rd_rdy;
    logic          rd_data_vld;
    logic [DW-1:0] rd_data;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_l2c_sram_4096x84_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE_LIMIT), .INIT_VALUE(INIT)
    ) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
        .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bwe(wr_bwe), .wr_rdy(wr_rdy),
        .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural single-port array: active-low enables, per-bit write mask, one-cycle read.
    logic [DW-1:0] sram_mem [4096];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [4096];
    logic          wp, rp;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, wb;
    int            wins;
    int            cyc;
    int            rdue [$];
    logic [DW-1:0] rexp [$];
    logic          prev_w, prev_r;
    logic [DW-1:0] e_wen;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    int            rgr;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd84();
        return {$urandom, $urandom, 20'($urandom)};
    endfunction

    function automatic int count_bad_entries();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (sram_mem[i] !== INIT) n++;
        return n;
    endfunction

    task automatic chk_reset();
        chk("rst_pins", 192'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            192'({1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}}));
        chk("rst_status", 192'({init_done, rd_data_vld, wr_rdy, rd_rdy}), 192'(4'b0000));
    endtask

    task automatic model_after_sweep();
        for (int i = 0; i < 4096; i++) ref_mem[i] = INIT;
        wp = 0; rp = 0; wins = 0;
        prev_w = 0; prev_r = 0;
        hold_a = '1; hold_d = INIT;
        rdue.delete(); rexp.delete();
    endtask

    // Assumes reset was released between clock edges just before the call.
    task automatic do_sweep(input int stop_at);
        int bad = 0;
        for (int i = 0; i < 4096; i++) begin
            @(posedge forever_cpuclk); #2;
            wr_vld = 1'($urandom); rd_vld = 1'($urandom);
            wr_addr = 12'($urandom); rd_addr = 12'($urandom);
            wr_data = rnd84(); wr_bwe = rnd84();
            if (i == 4095) begin wr_vld = 0; rd_vld = 0; end
            #1;
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_a !== 12'(i) ||
                sram_d !== INIT || init_done !== 1'b0 || wr_rdy !== 1'b0 || rd_rdy !== 1'b0 ||
                rd_data_vld !== 1'b0) bad++;
            if (i == stop_at) begin
                chk("sweep_partial_bad_cycles", 192'(bad), 192'(0));
                cpurst_b = 0; wr_vld = 0; rd_vld = 0;
                #1;
                chk_reset();
                repeat (2) @(posedge forever_cpuclk);
                #2 cpurst_b = 1;
                return;
            end
        end
        chk("sweep_bad_cycles", 192'(bad), 192'(0));
        @(posedge forever_cpuclk); #3;
        chk("post_sweep_idle", 192'({sram_cen, sram_gwen, sram_wen}), 192'({1'b1, 1'b1, {DW{1'b1}}}));
        chk("init_done_rise", 192'(init_done), 192'(1));
        model_after_sweep();
    endtask

    task automatic post_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] b);
        wp = 1; wa = a; wd = d; wb = b;
    endtask

    task automatic post_rd(input logic [AW-1:0] a);
        rp = 1; ra = a;
    endtask

    task automatic run_cycle();
        logic exp_v, gw, gr, e_cen, e_gwen;
        logic [DW-1:0] ew;
        @(posedge forever_cpuclk); #2;
        cyc++;
        e_cen  = !(prev_w || prev_r);
        e_gwen = !prev_w;
        ew     = prev_w ? e_wen : {DW{1'b1}};
        chk("sram_pins", 192'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            192'({e_cen, e_gwen, ew, hold_a, hold_d}));
        exp_v = (rdue.size() > 0) && (rdue[0] == cyc);
        chk("rd_data_vld", 192'(rd_data_vld), 192'(exp_v));
        if (exp_v) begin
            chk("rd_data", 192'(rd_data), 192'(rexp[0]));
            void'(rdue.pop_front());
            void'(rexp.pop_front());
        end
        wr_vld = wp; wr_addr = wa; wr_data = wd; wr_bwe = wb;
        rd_vld = rp; rd_addr = ra;
        #1;
        gw = wp && !(rp && wins == STARVE_LIMIT);
        gr = rp && !gw;
        chk("grant", 192'({wr_rdy, rd_rdy}), 192'({gw, gr}));
        if (rd_rdy === 1'b1) rgr++;
        prev_w = gw; prev_r = gr;
        if (gw) begin
            ref_mem[wa] = (ref_mem[wa] & ~wb) | (wd & wb);
            e_wen = ~wb; hold_a = wa; hold_d = wd;
            wins = rp ? wins + 1 : 0;
            wp = 0;
        end else if (gr) begin
            rdue.push_back(cyc + 2);
            rexp.push_back(ref_mem[ra]);
            hold_a = ra;
            wins = 0;
            rp = 0;
        end else begin
            wins = 0;
        end
    endtask

    initial begin
        logic [DW-1:0] pat;
        for (int i = 0; i < 4096; i++) sram_mem[i] <= '1;
        cpurst_b = 0;
        wr_vld = 0; rd_vld = 0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_bwe = '0;
        wp = 0; rp = 0; wa = '0; ra = '0; wd = '0; wb = '0;
        wins = 0; cyc = 0; rgr = 0; e_wen = '1;
        prev_w = 0; prev_r = 0; hold_a = '0; hold_d = '0;

        #12;
        chk_reset();
        @(posedge forever_cpuclk); #2 cpurst_b = 1;

        // Sweep interrupted by reset at address 2000, then a full restart from 0
        do_sweep(2000);
        do_sweep(-1);
        chk("init_mem_contents", 192'(count_bad_entries()), 192'(0));

        // Full write then read-after-write to the same address
        pat = {{10{8'hA5}}, 4'h5};
        post_wr(12'h123, pat, {DW{1'b1}});
        run_cycle();
        post_rd(12'h123);
        repeat (4) run_cycle();

        // Partial write: only bits [3:0] may land
        post_wr(12'd7, rnd84(), 84'h0F);
        run_cycle();
        post_rd(12'd7);
        repeat (4) run_cycle();

        // Continuous contention: reads get every fourth slot
        rgr = 0;
        for (int i = 0; i < 16; i++) begin
            if (!wp) post_wr(12'h200 + 12'($urandom_range(0, 15)), rnd84(), rnd84());
            if (!rp) post_rd(12'h200 + 12'($urandom_range(0, 15)));
            run_cycle();
        end
        chk("contention_read_grants", 192'(rgr), 192'(4));
        repeat (4) run_cycle();

        // Back-to-back reads of freshly written entries 0..2
        for (int i = 0; i < 3; i++) begin
            post_wr(12'(i), rnd84(), {DW{1'b1}});
            run_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            post_rd(12'(i));
            run_cycle();
        end
        repeat (4) run_cycle();

        // Random mixed traffic over a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if (!wp && ($urandom_range(0, 2) != 0)) post_wr(12'($urandom_range(0, 15)), rnd84(), rnd84());
            if (!rp && ($urandom_range(0, 1) != 0)) post_rd(12'($urandom_range(0, 15)));
            run_cycle();
        end
        wp = 0; rp = 0;
        repeat (4) run_cycle();

        // Reset with a read in flight: its data must never be flagged valid
        post_rd(12'h123);
        run_cycle();
        @(posedge forever_cpuclk); #2;
        cpurst_b = 0; wr_vld = 0; rd_vld = 0;
        #1;
        chk_reset();
        rdue.delete(); rexp.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge forever_cpuclk); #3;
            chk("inflight_rd_dropped", 192'(rd_data_vld), 192'(0));
        end
        cpurst_b = 1;
        do_sweep(-1);
        chk("reinit_mem_contents", 192'(count_bad_entries()), 192'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ct_l2c_sram_4096x84_ctrl.md
Name: ct_l2c_sram_4096x84_ctrl

Overview:
- Sequencing and arbitration controller in front of one 4096x84 single-port L2C array (A/CEN/GWEN/WEN/D/Q macro; CEN, GWEN and WEN are all active-low).
- After reset it sweeps every entry to INIT_VALUE, then shares the single port between a write requester and a read requester.
- Writes have priority, with a starvation guard for reads.
- All SRAM pins are registered; read data returns with fixed latency.

Parameters:
- ADDR_WIDTH, 12, SRAM address width (depth = 2^ADDR_WIDTH).
- DATA_WIDTH, 84, SRAM data / bit-write-enable width.
- STARVE_LIMIT, 3, consecutive write grants allowed while a read waits.
- INIT_VALUE, 84'h0, data written to every entry during the init sweep.

Ports:
- forever_cpuclk  in  1  clock; all state on the rising edge.
- cpurst_b  in  1  asynchronous, active-low reset.
- wr_vld  in  1  write request valid.
- wr_addr  in  12  write address.
- wr_data  in  84  write data.
- wr_bwe  in  84  write bit enables, active-high (1 = write bit).
- wr_rdy  out  1  write accepted this cycle (wr_vld & wr_rdy = grant).
- rd_vld  in  1  read request valid.
- rd_addr  in  12  read address.
- rd_rdy  out  1  read accepted this cycle.
- rd_data_vld  out  1  read data valid pulse.
- rd_data  out  84  read data.
- init_done  out  1  high once the sweep completes; stays high until reset.
- sram_a  out  12  to SRAM A.
- sram_cen  out  1  to SRAM CEN.
- sram_gwen  out  1  to SRAM GWEN.
- sram_wen  out  84  to SRAM WEN.
- sram_d  out  84  to SRAM D.
- sram_q  in  84  from SRAM Q.

Behaviour:
- Reset values:
  - init_done 0; sram_cen 1; sram_gwen 1; sram_wen all 1s; sram_a 0; sram_d 0.
  - rd_data_vld 0; read pipe valids 0; init counter 0; starvation counter 0; state INIT.
- State INIT:
  - Every cycle, register an SRAM write: sram_cen=0, sram_gwen=0, sram_wen=0, sram_a=counter, sram_d=INIT_VALUE.
  - Counter increments from 0 to 4095; the write to 4095 is the last.
  - wr_rdy=0 and rd_rdy=0 throughout.
  - On the cycle after the 4095 write is issued: state goes to RUN, init_done=1.
  - Total 4096 write cycles.
- State RUN: grant is combinational from the valid inputs and the starvation counter.
  - Write wins when wr_vld is high, unless rd_vld=1 and the counter equals STARVE_LIMIT; in that case the read wins.
  - rd_rdy/wr_rdy are high only for the winner; the loser's rdy is 0. A requester must hold valid and payload until granted.
- Pin registration: the grant in cycle N drives the SRAM pins in cycle N+1.
  - Write: cen=0, gwen=0, wen=~wr_bwe, a=wr_addr, d=wr_data.
  - Read: cen=0, gwen=1, wen all 1s, a=rd_addr, d held.
  - No grant: cen=1, gwen=1, wen all 1s; a and d hold their previous values.
- Read latency: the SRAM Q is valid in cycle N+2. rd_data_vld=1 and rd_data=sram_q in cycle N+2, combinational from the registered read-pipe valid. Data is not held afterwards.
- Throughput: one access per cycle, back-to-back, mixed in any order.
- Starvation counter (2 bits, saturating at STARVE_LIMIT):
  - +1 on a write grant while rd_vld=1.
  - Cleared on a read grant, or in any cycle with rd_vld=0.
- Hazard: a read granted the cycle after a write to the same address returns the new data. This follows from SRAM ordering; no bypass logic.
- Mid-operation reset: asserting cpurst_b forces all reset values immediately.
  - An in-flight read is dropped (no rd_data_vld).
  - On release, the sweep restarts from address 0.
- Inputs are ignored while in INIT, even if valid is high.

Test Plan:
- Reset release, no requests: exactly 4096 cycles with sram_cen=0 and sram_gwen=0, addresses 0..4095 in order, sram_d=0. init_done rises on the next cycle. rdy=0 throughout.
- After init, write addr 0x123 data 84'hA5...5 with bwe all 1s, then read 0x123: sram_wen=0 one cycle after the write grant. rd_data_vld occurs 2 cycles after the read grant with rd_data=84'hA5...5.
- Partial write with bwe=84'h0F at addr 7 after init: sram_wen=~84'h0F. A following read returns 84'h0F&wdata in bits [3:0] and zeros elsewhere.
- wr_vld and rd_vld held high continuously: grant pattern W,W,W,R repeating. rd_data_vld appears every 4th cycle with a 2-cycle offset.
- Reads to 0,1,2 on three consecutive cycles: rd_data_vld high for 3 consecutive cycles with the matching data. No idle cycles on sram_cen.
- cpurst_b pulsed at sweep address 2000: outputs return to reset values asynchronously. The sweep restarts at 0 and init_done is delayed by a full 4096 cycles. Pulsed with a read in flight: no rd_data_vld for that read.
